prio_encoder_n: RTL and testbench
=================================

# prio_encoder_n

Parametrised, registered N-to-log2(N) encoder with valid/ready handshakes on both sides and a selectable fixed-priority or round-robin arbitration mode. It is the general-width successor of the team's 4-to-2 encoder. It sits between request sources (interrupt lines, channel-busy flags) and a downstream consumer that needs a binary index. It stalls cleanly under backpressure and keeps round-robin fairness state across requests.

## Interface
- `N`, default 8: number of request inputs; legal range 2..256.
- `MODE`, default 0: 0 = fixed priority (highest index wins); 1 = round-robin.
- `W`: localparam, `$clog2(N)`; width of the encoded index. Not overridable.

Ports:
- `clk`  input  1  single clock; all state updates on rising edge.
- `rst`  input  1  synchronous, active-high reset.
- `in`  input  N  request vector; bit i requests index i.
- `in_valid`  input  1  `in` is meaningful this cycle.
- `in_ready`  output  1  block can accept `in` this cycle.
- `e`  output  W  encoded index of the granted request.
- `e_valid`  output  1  `e` holds a result.
- `e_ready`  input  1  consumer takes `e` this cycle.
- `err`  output  1  present only with `PENC_MULTIHOT_CHK_EN`: accepted vector had more than one bit set.

## Operation
- Accept happens when `in_valid & in_ready`. `in_ready = ~e_valid | e_ready`, which is combinational and gives full throughput.
- Accept with `in != 0`:
  - Grant index g is computed combinationally.
  - On the next edge: `e <= g`, `e_valid <= 1`.
- Accept with `in == 0`:
  - The vector is consumed and discarded.
  - `e_valid` clears if the current output was taken in the same cycle; otherwise it stays at its prior value.
  - `e` is unchanged and `ptr` is unchanged.
- Fixed mode (`MODE=0`): g is the highest set bit index.
- Round-robin mode (`MODE=1`):
  - W-bit register `ptr` holds the last granted index.
  - Search order is ptr+1, ptr+2, … N-1, 0, … ptr. The first set bit wins.
  - Wrap is at N-1 → 0, not at 2^W, including for non-power-of-two N.
  - On a nonzero accept, `ptr <= g`.
  - `ptr` ignores `in` while not accepting.
- Output hold: while `e_valid & ~e_ready`:
  - `e`, `e_valid` and `err` stay stable.
  - `in_ready = 0`, so `in` is ignored.
- `e_valid` clears when `e_ready` is high and there is no new nonzero accept in the same cycle.
- Simultaneous take and accept: the output is consumed and the new result is loaded on the same edge, with no bubble.
- `in` and `in_valid` changing while `in_ready = 0` have no effect.

## Timing
- Latency: 1 cycle from accept edge to `e_valid` high.
- Throughput: 1 result per cycle with `e_ready` held high.
- Reset values:
  - `e = 0`, `e_valid = 0`, `err = 0`.
  - `ptr = N-1`, so the first round-robin search starts at index 0.
  - `in_ready = 1` in the cycle after reset.
- Reset mid-operation: a held, unconsumed result is dropped and `ptr` returns to N-1. `rst` has priority over accept on the same edge.
- There is no combinational path from `in` to `e`. The only combinational output path is `e_ready`/`e_valid` → `in_ready`.

## Configuration
- `PENC_MULTIHOT_CHK_EN` defined:
  - Port `err` exists.
  - On every nonzero accept, `err <= (popcount(in) > 1)`. `err` is updated alongside `e` and held with it under backpressure.
  - The grant is still produced per the selected MODE.
- `PENC_MULTIHOT_CHK_EN` undefined:
  - Port `err` and its logic are absent.
  - All other behaviour is identical.

## Test plan
- Fixed, N=8: accept `in=8'b0010_0100` with `e_ready=1` → next cycle `e=5`, `e_valid=1`. Accept `8'b0000_0001` → `e=0`.
- Round-robin, N=8: `in=8'hFF` held valid for 9 cycles with `e_ready=1` → `e` sequence 0,1,2,…,7,0. Then `in=8'b1000_0010` → grants alternate 7 and 1.
- Round-robin, N=5: `in=5'b10001` repeated → grants 0,4,0,4. This exercises wrap at 4 → 0 and shows `ptr` never reaching 5–7.
- Backpressure: produce `e=3`, then hold `e_ready=0` for 4 cycles while driving new `in` → `in_ready=0`, `e=3` stable, no accept. Raising `e_ready` with `in=8'h40` valid → same edge consumes 3 and the next cycle shows `e=6`.
- Zero vector and reset:
  - Accept `in=0` → `e_valid` stays 0 and `ptr` is unchanged.
  - Assert `rst` while `e_valid=1` and stalled → next cycle `e_valid=0`, `e=0`. A following `8'hFF` in MODE=1 grants 0.
- With `PENC_MULTIHOT_CHK_EN`, fixed mode: accept `8'b0000_0011` → `e=1`, `err=1`. Accept `8'b0001_0000` → `e=4`, `err=0`.

Source files
------------

// File: rtl/prio_encoder_n.sv
// Registered N-to-log2(N) encoder with valid/ready on both sides; fixed-priority or round-robin grant.
// Optional multi-hot flag output err is built only when PENC_MULTIHOT_CHK_EN is defined.
module prio_encoder_n #(
    parameter  int N    = 8,
    parameter  int MODE = 0,
    localparam int W    = $clog2(N)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] in,
    input  logic         in_valid,
    output logic         in_ready,
    output logic [W-1:0] e,
    output logic         e_valid,
`ifdef PENC_MULTIHOT_CHK_EN
    output logic         err,
`endif
    input  logic         e_ready
);

    logic [W-1:0] e_p1;
    logic         vld_p1;
    logic [W-1:0] ptr;
    logic [W-1:0] grant_p0;
    logic         accept_p0;
    logic         nonzero_p0;

    function automatic logic [W-1:0] grant_fixed(input logic [N-1:0] req);
        logic [W-1:0] g;
        g = '0;
        for (int i = 0; i < N; i++) begin
            if (req[i]) g = W'(i);
        end
        return g;
    endfunction

    // First set bit strictly above 'last' wins; otherwise wrap to the lowest set bit.
    // Both candidates are below N, so the wrap is at N-1 -> 0 for any N.
    function automatic logic [W-1:0] grant_rr(input logic [N-1:0] req, input logic [W-1:0] last);
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        logic         hi_found;
        hi       = '0;
        lo       = '0;
        hi_found = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req[i]) begin
                lo = W'(i);
                if (i > int'(last)) begin
                    hi       = W'(i);
                    hi_found = 1'b1;
                end
            end
        end
        return hi_found ? hi : lo;
    endfunction

`ifdef PENC_MULTIHOT_CHK_EN
    function automatic logic multi_hot(input logic [N-1:0] req);
        return (req & (req - N'(1))) != '0;
    endfunction

    logic err_p1;
`endif

    assign in_ready   = ~vld_p1 | e_ready;
    assign accept_p0  = in_valid & in_ready;
    assign nonzero_p0 = |in;
    assign grant_p0   = (MODE == 1) ? grant_rr(in, ptr) : grant_fixed(in);

    // ---- stage p0 -> p1: registered result ----
    always_ff @(posedge clk) begin
        if (rst) begin
            e_p1   <= '0;
            vld_p1 <= 1'b0;
            ptr    <= W'(N - 1);
`ifdef PENC_MULTIHOT_CHK_EN
            err_p1 <= 1'b0;
`endif
        end else if (accept_p0 && nonzero_p0) begin
            e_p1   <= grant_p0;
            vld_p1 <= 1'b1;
            if (MODE == 1) ptr <= grant_p0;
`ifdef PENC_MULTIHOT_CHK_EN
            err_p1 <= multi_hot(in);
`endif
        end else if (e_ready) begin
            vld_p1 <= 1'b0;
        end
    end

    assign e       = e_p1;
    assign e_valid = vld_p1;
`ifdef PENC_MULTIHOT_CHK_EN
    assign err     = err_p1;
`endif

endmodule

// File: tb/tb_prio_encoder_n.sv
// Directed bench for prio_encoder_n: fixed N=8, round-robin N=8 and round-robin N=5 instances.
// err checks are compiled in when PENC_MULTIHOT_CHK_EN is defined.
module tb_prio_encoder_n;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [7:0] fx_in;  logic fx_v = 1'b0; logic fx_rdy; logic [2:0] fx_e; logic fx_ev; logic fx_er = 1'b0;
    logic [7:0] r8_in;  logic r8_v = 1'b0; logic r8_rdy; logic [2:0] r8_e; logic r8_ev; logic r8_er = 1'b0;
    logic [4:0] r5_in;  logic r5_v = 1'b0; logic r5_rdy; logic [2:0] r5_e; logic r5_ev; logic r5_er = 1'b0;
`ifdef PENC_MULTIHOT_CHK_EN
    logic fx_err, r8_err, r5_err;
`endif

    prio_encoder_n #(.N(8), .MODE(0)) u_fx (
        .clk(clk), .rst(rst), .in(fx_in), .in_valid(fx_v), .in_ready(fx_rdy),
        .e(fx_e), .e_valid(fx_ev),
`ifdef PENC_MULTIHOT_CHK_EN
        .err(fx_err),
`endif
        .e_ready(fx_er));

    prio_encoder_n #(.N(8), .MODE(1)) u_r8 (
        .clk(clk), .rst(rst), .in(r8_in), .in_valid(r8_v), .in_ready(r8_rdy),
        .e(r8_e), .e_valid(r8_ev),
`ifdef PENC_MULTIHOT_CHK_EN
        .err(r8_err),
`endif
        .e_ready(r8_er));

    prio_encoder_n #(.N(5), .MODE(1)) u_r5 (
        .clk(clk), .rst(rst), .in(r5_in), .in_valid(r5_v), .in_ready(r5_rdy),
        .e(r5_e), .e_valid(r5_ev),
`ifdef PENC_MULTIHOT_CHK_EN
        .err(r5_err),
`endif
        .e_ready(r5_er));

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    typedef struct {
        logic [7:0] in;
        logic       v;
        logic       r;
        logic       exp_rdy;
        logic [2:0] exp_e;
        logic       exp_vld;
        logic       exp_err;
    } vec_t;

    vec_t tbl[17];

    logic r8_prev_v = 1'b0;
    logic r5_prev_v = 1'b0;

    task automatic cyc_r8(input logic [7:0] i, input logic v, input logic r,
                          input logic [2:0] exp_e, input logic exp_v, input string nm);
        r8_in = i; r8_v = v; r8_er = r;
        #1;
        chk({nm, " in_ready"}, r8_rdy, !r8_prev_v || r);
        @(posedge clk); #1;
        chk({nm, " e"}, r8_e, exp_e);
        chk({nm, " e_valid"}, r8_ev, exp_v);
        r8_prev_v = exp_v;
    endtask

    task automatic cyc_r5(input logic [4:0] i, input logic v, input logic r,
                          input logic [2:0] exp_e, input logic exp_v, input string nm);
        r5_in = i; r5_v = v; r5_er = r;
        #1;
        chk({nm, " in_ready"}, r5_rdy, !r5_prev_v || r);
        @(posedge clk); #1;
        chk({nm, " e"}, r5_e, exp_e);
        chk({nm, " e_valid"}, r5_ev, exp_v);
        r5_prev_v = exp_v;
    endtask

    initial begin
        //          in     v  r  rdy e  vld err
        tbl[0]  = '{8'h24, 1, 1, 1, 5, 1, 1};
        tbl[1]  = '{8'h01, 1, 1, 1, 0, 1, 0};
        tbl[2]  = '{8'h80, 1, 1, 1, 7, 1, 0};
        tbl[3]  = '{8'h00, 1, 1, 1, 7, 0, 0};
        tbl[4]  = '{8'h00, 1, 0, 1, 7, 0, 0};
        tbl[5]  = '{8'h08, 1, 0, 1, 3, 1, 0};
        tbl[6]  = '{8'h40, 1, 0, 0, 3, 1, 0};
        tbl[7]  = '{8'hFF, 1, 0, 0, 3, 1, 0};
        tbl[8]  = '{8'h01, 1, 0, 0, 3, 1, 0};
        tbl[9]  = '{8'h40, 0, 0, 0, 3, 1, 0};
        tbl[10] = '{8'h40, 1, 1, 1, 6, 1, 0};
        tbl[11] = '{8'h00, 0, 1, 1, 6, 0, 0};
        tbl[12] = '{8'h55, 0, 1, 1, 6, 0, 0};
        tbl[13] = '{8'h10, 1, 1, 1, 4, 1, 0};
        tbl[14] = '{8'h03, 1, 1, 1, 1, 1, 1};
        tbl[15] = '{8'h0F, 1, 0, 0, 1, 1, 1};
        tbl[16] = '{8'h00, 1, 1, 1, 1, 0, 1};

        fx_in = '0; r8_in = '0; r5_in = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        #1;
        chk("reset fx e", fx_e, 0);
        chk("reset fx e_valid", fx_ev, 0);
        chk("reset fx in_ready", fx_rdy, 1);
        chk("reset r8 e_valid", r8_ev, 0);
        chk("reset r5 e_valid", r5_ev, 0);
`ifdef PENC_MULTIHOT_CHK_EN
        chk("reset fx err", fx_err, 0);
`endif

        // Fixed priority, N=8
        for (int i = 0; i < 17; i++) begin
            fx_in = tbl[i].in; fx_v = tbl[i].v; fx_er = tbl[i].r;
            #1;
            chk($sformatf("fx row %0d in_ready", i), fx_rdy, tbl[i].exp_rdy);
            @(posedge clk); #1;
            chk($sformatf("fx row %0d e", i), fx_e, tbl[i].exp_e);
            chk($sformatf("fx row %0d e_valid", i), fx_ev, tbl[i].exp_vld);
`ifdef PENC_MULTIHOT_CHK_EN
            chk($sformatf("fx row %0d err", i), fx_err, tbl[i].exp_err);
`endif
        end
        fx_v = 1'b0;

        // Round-robin, N=5: wrap at 4 -> 0
        cyc_r5(5'b10001, 1, 1, 0, 1, "r5 g0");
        cyc_r5(5'b10001, 1, 1, 4, 1, "r5 g1");
        cyc_r5(5'b10001, 1, 1, 0, 1, "r5 g2");
        cyc_r5(5'b10001, 1, 1, 4, 1, "r5 g3");
        cyc_r5(5'b00000, 0, 1, 4, 0, "r5 drain");

        // Round-robin, N=8: full rotation then two-request alternation
        for (int k = 0; k < 9; k++)
            cyc_r8(8'hFF, 1, 1, 3'(k % 8), 1, $sformatf("r8 ff%0d", k));
        cyc_r8(8'h82, 1, 1, 1, 1, "r8 alt0");
        cyc_r8(8'h82, 1, 1, 7, 1, "r8 alt1");
        cyc_r8(8'h82, 1, 1, 1, 1, "r8 alt2");
        cyc_r8(8'h82, 1, 1, 7, 1, "r8 alt3");
        cyc_r8(8'h82, 1, 1, 1, 1, "r8 alt4");
        cyc_r8(8'h00, 1, 1, 1, 0, "r8 zero");
        cyc_r8(8'hFF, 1, 1, 2, 1, "r8 after zero");
        cyc_r8(8'hFF, 1, 0, 2, 1, "r8 stall0");
        cyc_r8(8'h08, 1, 0, 2, 1, "r8 stall1");

        // Reset while a stalled result is held; rst beats the pending accept
        r8_in = 8'hFF; r8_v = 1'b1; r8_er = 1'b1; rst = 1'b1;
        @(posedge clk); #1;
        chk("r8 midreset e", r8_e, 0);
        chk("r8 midreset e_valid", r8_ev, 0);
        rst = 1'b0;
        r8_prev_v = 1'b0;
        cyc_r8(8'hFF, 1, 1, 0, 1, "r8 post reset");
        cyc_r8(8'h00, 0, 1, 0, 0, "r8 drain");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
